// File: rtl/address_range_translator_pkg.sv
// Shared constants for the address range translator: default address width and
// the configuration values restored by reset (identity map, every address hits).
package address_range_translator_pkg;

    localparam int ADDR_WIDTH_DEF = 10;

    localparam logic [ADDR_WIDTH_DEF-1:0] CFG_BASE_INIT   = '0;
    localparam logic [ADDR_WIDTH_DEF-1:0] CFG_BOUND_INIT  = '1;
    localparam logic [ADDR_WIDTH_DEF-1:0] CFG_OFFSET_INIT = '0;

endpackage

// File: rtl/address_decoder_arithmetic.sv
// Inclusive range compare of an address against [base, bound].
// An inverted range (base > bound) can never satisfy both compares, so it never hits.
module address_decoder_arithmetic
    import address_range_translator_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] bound,
    output logic                  hit
);

    assign hit = (addr >= base) && (addr <= bound);

endmodule

// File: rtl/address_range_translator.sv
// Two-stage handshaked translator: S1 registers the address and range hit,
// S2 registers the translated address and drives the result port.
module address_range_translator
    import address_range_translator_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_wren,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_bound,
    input  logic [ADDR_WIDTH-1:0] cfg_offset,
    output logic                  cfg_ready,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_hit,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [ADDR_WIDTH-1:0] out_raw_addr
);

    logic [ADDR_WIDTH-1:0] base_q, bound_q, offset_q;
    logic                  s1_valid, s1_hit;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic                  s2_valid;
    logic                  dec_hit;
    logic                  s1_adv, s2_adv, cfg_take, in_fire;
    logic [ADDR_WIDTH-1:0] s1_xlat;

    // Handshake: a beat moves when valid && ready. Each ready is derived only
    // from downstream occupancy, out_ready and cfg_wren, never from any valid
    // on the same port. Config writes are only taken with both stages empty,
    // so in-flight addresses always see the config they were accepted under.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign cfg_ready = !s1_valid && !s2_valid;
    assign cfg_take  = cfg_wren && cfg_ready;
    assign in_ready  = s1_adv && !cfg_take;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    // Wrap-around is intentional: the result is taken mod 2^ADDR_WIDTH.
    assign s1_xlat = s1_addr - base_q + offset_q;

    address_decoder_arithmetic #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_decoder (
        .addr  (in_addr),
        .base  (base_q),
        .bound (bound_q),
        .hit   (dec_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q   <= ADDR_WIDTH'(CFG_BASE_INIT);
            bound_q  <= ADDR_WIDTH'(CFG_BOUND_INIT);
            offset_q <= ADDR_WIDTH'(CFG_OFFSET_INIT);
        end else if (cfg_take) begin
            base_q   <= cfg_base;
            bound_q  <= cfg_bound;
            offset_q <= cfg_offset;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_addr  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_hit  <= dec_hit;
                s1_addr <= in_addr;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid     <= 1'b0;
            out_hit      <= 1'b0;
            out_addr     <= '0;
            out_raw_addr <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_hit      <= s1_hit;
                out_addr     <= s1_hit ? s1_xlat : s1_addr;
                out_raw_addr <= s1_addr;
            end
        end
    end

endmodule

// File: tb/tb_address_range_translator.sv
// Bench for address_range_translator: directed scenarios plus randomized traffic,
// checked against a range/offset reference model and an expected-result queue.
module tb_address_range_translator;

    localparam int AW   = 10;
    localparam int RW   = 2 * AW + 1;
    localparam int SPAN = 1 << AW;

    logic          clock, reset;
    logic          cfg_wren, cfg_ready;
    logic [AW-1:0] cfg_base, cfg_bound, cfg_offset;
    logic          in_valid, in_ready;
    logic [AW-1:0] in_addr;
    logic          out_valid, out_ready, out_hit;
    logic [AW-1:0] out_addr, out_raw_addr;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    int            rdy_mode = 0;  // 0: always ready, 1: stalled, 2: random
    logic [RW-1:0] exp_q[$];
    int            pop_cyc_q[$];
    logic [AW-1:0] m_base   = '0;
    logic [AW-1:0] m_bound  = '1;
    logic [AW-1:0] m_offset = '0;
    logic          hold_pending = 1'b0;
    logic [RW-1:0] held;

    address_range_translator #(.ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_wren     (cfg_wren),
        .cfg_base     (cfg_base),
        .cfg_bound    (cfg_bound),
        .cfg_offset   (cfg_offset),
        .cfg_ready    (cfg_ready),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_hit      (out_hit),
        .out_addr     (out_addr),
        .out_raw_addr (out_raw_addr)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: hit iff base <= a <= bound; translated = (a - base + offset) mod 2^AW.
    function automatic logic [RW-1:0] model(input logic [AW-1:0] a);
        int   t;
        logic h;
        h = (int'(a) >= int'(m_base)) && (int'(a) <= int'(m_bound));
        t = int'(a);
        if (h) begin
            t = (int'(a) - int'(m_base) + int'(m_offset)) % SPAN;
            if (t < 0) t += SPAN;
        end
        return {h, AW'(t), a};
    endfunction

    // out_ready driver, updated a little after each rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clock) begin : monitor
        int            occ;
        logic          exp_in_rdy;
        logic [RW-1:0] got, e;
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            occ = exp_q.size();
            check("cfg_ready", 32'(cfg_ready), 32'(occ == 0));
            exp_in_rdy = (occ < 2 || out_ready) && !(cfg_wren && occ == 0);
            check("in_ready", 32'(in_ready), 32'(exp_in_rdy));
            got = {out_hit, out_addr, out_raw_addr};
            if (hold_pending) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(got), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_result", 32'(got), 32'(e));
                    pop_cyc_q.push_back(cyc);
                end
            end
            hold_pending = out_valid && !out_ready;
            held = got;
            if (in_valid && exp_in_rdy) exp_q.push_back(model(in_addr));
            if (cfg_wren && occ == 0) begin
                m_base   = cfg_base;
                m_bound  = cfg_bound;
                m_offset = cfg_offset;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a);
        int   n;
        logic ok;
        n = 0;
        in_valid = 1'b1;
        in_addr  = a;
        forever begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
            if (ok) break;
            n++;
            if (n > 100) begin
                check("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [AW-1:0] b, input logic [AW-1:0] bd, input logic [AW-1:0] o);
        cfg_wren   = 1'b1;
        cfg_base   = b;
        cfg_bound  = bd;
        cfg_offset = o;
        step();
        cfg_wren = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_base   = '0;
        m_bound  = '1;
        m_offset = '0;
    endtask

    initial begin
        int            r;
        logic [AW-1:0] rb, rbd;
        reset      = 1'b1;
        cfg_wren   = 1'b0;
        cfg_base   = '0;
        cfg_bound  = '0;
        cfg_offset = '0;
        in_valid   = 1'b0;
        in_addr    = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_raw", 32'(out_raw_addr), 32'd0);
        reset = 1'b0;
        step();

        // identity map after reset, 2-cycle latency
        send(10'h000);
        @(negedge clock) check("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clock) check("lat_cycle2", 32'(out_valid), 32'd1);
        step();
        send(10'h3FF);
        @(negedge clock) check("lat_cycle1b", 32'(out_valid), 32'd0);
        @(negedge clock) check("lat_cycle2b", 32'(out_valid), 32'd1);
        step();
        drain();

        // window [0x100,0x1FF], back-to-back
        cfg_write(10'h100, 10'h1FF, 10'h000);
        pop_cyc_q.delete();
        send(10'h0FF);
        send(10'h100);
        send(10'h1FF);
        send(10'h200);
        drain();
        check("b2b_count", 32'(pop_cyc_q.size()), 32'd4);
        if (pop_cyc_q.size() == 4)
            check("b2b_span", 32'(pop_cyc_q[3] - pop_cyc_q[0]), 32'd3);

        // wrap-around translation, then an inverted range
        cfg_write(10'h3F0, 10'h3FF, 10'h3F8);
        send(10'h3F9);
        send(10'h3EF);
        drain();
        cfg_write(10'h200, 10'h100, 10'h055);
        send(10'h100);
        send(10'h200);
        send(10'h180);
        repeat (12) send(AW'($urandom_range(0, SPAN - 1)));
        drain();
        cfg_write(10'h155, 10'h155, 10'h2A0);
        send(10'h154);
        send(10'h155);
        send(10'h156);
        drain();

        // backpressure: 4 addresses against a 5+ cycle stall
        cfg_write(10'h000, 10'h1FF, 10'h200);
        rdy_mode = 1;
        fork
            begin
                for (int i = 0; i < 4; i++) send(AW'($urandom_range(0, SPAN - 1)));
            end
            begin
                repeat (7) step();
                rdy_mode = 0;
            end
        join
        drain();

        // config write against a busy pipeline is dropped
        rdy_mode = 1;
        send(10'h010);
        send(10'h020);
        cfg_write(10'h000, 10'h00F, 10'h300);
        rdy_mode = 0;
        drain();
        send(10'h005);
        drain();

        // config and address in the same cycle on an empty pipeline
        in_valid   = 1'b1;
        in_addr    = 10'h0A0;
        cfg_wren   = 1'b1;
        cfg_base   = 10'h080;
        cfg_bound  = 10'h0FF;
        cfg_offset = 10'h100;
        step();
        cfg_wren = 1'b0;
        send(10'h0A0);
        drain();

        // reset with two results in flight
        rdy_mode = 1;
        send(10'h111);
        send(10'h222);
        @(posedge clock);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_addr", 32'(out_addr), 32'd0);
        check("midrst_out_raw", 32'(out_raw_addr), 32'd0);
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (2) step();
        reset    = 1'b0;
        rdy_mode = 0;
        step();
        send(10'h3C3);
        send(10'h111);
        drain();

        // randomized traffic with random stalls and config writes
        rdy_mode = 2;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                rb  = AW'($urandom_range(0, SPAN - 1));
                rbd = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, SPAN - 1))
                                                  : AW'($urandom_range(int'(rb), SPAN - 1));
                cfg_write(rb, rbd, AW'($urandom_range(0, SPAN - 1)));
            end else if (r < 3) begin
                step();
            end else begin
                send(AW'($urandom_range(0, SPAN - 1)));
            end
        end
        rdy_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
